// File: rtl/tmr_clock_divider.sv
// Triplicated integer clock divider for radiation-tolerant slow-clock generation.
// Three counter replicas are majority-voted and rewritten with the voted next
// value every cycle. A single upset in one replica is therefore repaired on the
// next edge and never reaches clock_out. The design flags the disagreement on
// tmr_err for one cycle.
module tmr_clock_divider #(
  parameter logic [31:0] DIVISOR = 32'd4,
  parameter int unsigned CNT_W   = 28
) (
  input  logic             clock_in,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       seu_inject,
  output logic             clock_out,
  output logic [CNT_W-1:0] cnt_voted,
  output logic             tmr_err
);

  // Elaboration guards: a ratio below 2 is meaningless, and the terminal
  // count must fit in the counter.
  if (DIVISOR < 32'd2) begin : g_divisor_too_small
    $error("tmr_clock_divider: DIVISOR must be at least 2");
  end
  if (64'(DIVISOR) > ((64'd1 << CNT_W) - 64'd1)) begin : g_divisor_too_wide
    $error("tmr_clock_divider: DIVISOR does not fit in CNT_W bits");
  end

  // Terminal count; the counter wraps to 0 here.
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIVISOR - 32'd1);
  // First count value with the output high; this gives floor/ceil duty.
  localparam logic [CNT_W-1:0] HALF   = CNT_W'(DIVISOR >> 1);

  // Bitwise 2-of-3 majority vote.
  function automatic logic [CNT_W-1:0] maj3(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b,
    input logic [CNT_W-1:0] c
  );
    return (a & b) | (b & c) | (a & c);
  endfunction

  // Set when any replica disagrees with the vote.
  function automatic logic any_mismatch(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b,
    input logic [CNT_W-1:0] c,
    input logic [CNT_W-1:0] v
  );
    return (a != v) | (b != v) | (c != v);
  endfunction

  // The replicas must survive synthesis as three separate registers.
  (* keep = "true", dont_touch = "true" *) logic [CNT_W-1:0] cnt_a_r;
  (* keep = "true", dont_touch = "true" *) logic [CNT_W-1:0] cnt_b_r;
  (* keep = "true", dont_touch = "true" *) logic [CNT_W-1:0] cnt_c_r;

  logic             clock_out_r;
  logic             tmr_err_r;
  logic [CNT_W-1:0] voted_s;
  logic [CNT_W-1:0] nxt_s;
  logic [CNT_W-1:0] base_s;
  logic             nxt_high_s;

  // Vote the replicas, then derive the next count. The >= test also catches
  // out-of-range values left behind by a double upset, so the voted value
  // always returns to 0..DIVISOR-1.
  always_comb begin
    voted_s = maj3(cnt_a_r, cnt_b_r, cnt_c_r);
    nxt_s   = '0;
    if (voted_s >= DIV_M1) begin
      nxt_s = '0;
    end else begin
      nxt_s = voted_s + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    base_s = voted_s;
    if (enable) begin
      base_s = nxt_s;
    end else begin
      base_s = voted_s;
    end
    nxt_high_s = (nxt_s >= HALF);
  end

  // Replica update. Every replica is rewritten with the common value, which
  // scrubs it. The test hook flips bit 0 of the selected replicas only.
  always_ff @(posedge clock_in) begin
    if (rst) begin
      cnt_a_r <= '0;
      cnt_b_r <= '0;
      cnt_c_r <= '0;
    end else begin
      cnt_a_r <= base_s ^ {{(CNT_W-1){1'b0}}, seu_inject[0]};
      cnt_b_r <= base_s ^ {{(CNT_W-1){1'b0}}, seu_inject[1]};
      cnt_c_r <= base_s ^ {{(CNT_W-1){1'b0}}, seu_inject[2]};
    end
  end

  // Divided clock. It is registered from the next count, so it changes on the
  // same edge as the counter and holds while disabled.
  always_ff @(posedge clock_in) begin
    if (rst) begin
      clock_out_r <= 1'b0;
    end else if (enable) begin
      clock_out_r <= nxt_high_s;
    end else begin
      clock_out_r <= clock_out_r;
    end
  end

  // One-cycle error pulse when the replicas disagreed before this edge.
  always_ff @(posedge clock_in) begin
    if (rst) begin
      tmr_err_r <= 1'b0;
    end else begin
      tmr_err_r <= any_mismatch(cnt_a_r, cnt_b_r, cnt_c_r, voted_s);
    end
  end

  assign clock_out = clock_out_r;
  assign tmr_err   = tmr_err_r;
  assign cnt_voted = voted_s;

endmodule

// File: tb/tb_tmr_clock_divider.sv
// Directed bench for tmr_clock_divider.
// Three instances are used, with DIVISOR = 4, 2 and 5. The DIVISOR=4 instance
// receives the freeze, upset and mid-period reset sequences.
module tb_tmr_clock_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  seu4;
  logic [2:0]  seu_off;
  logic        co4, co2, co5;
  logic        te4, te2, te5;
  logic [27:0] cv4, cv2, cv5;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Free-running master clock.
  always #5 clk = ~clk;

  tmr_clock_divider #(.DIVISOR(32'd4), .CNT_W(28)) dut4 (
    .clock_in(clk), .rst(rst), .enable(enable), .seu_inject(seu4),
    .clock_out(co4), .cnt_voted(cv4), .tmr_err(te4));
  tmr_clock_divider #(.DIVISOR(32'd2), .CNT_W(28)) dut2 (
    .clock_in(clk), .rst(rst), .enable(enable), .seu_inject(seu_off),
    .clock_out(co2), .cnt_voted(cv2), .tmr_err(te2));
  tmr_clock_divider #(.DIVISOR(32'd5), .CNT_W(28)) dut5 (
    .clock_in(clk), .rst(rst), .enable(enable), .seu_inject(seu_off),
    .clock_out(co5), .cnt_voted(cv5), .tmr_err(te5));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input int cnt, input logic clko, input logic err);
    check({tag, ".cnt"}, 32'(cv4), 32'(cnt));
    check({tag, ".clk"}, 32'(co4), 32'(clko));
    check({tag, ".err"}, 32'(te4), 32'(err));
  endtask

  // Hand-computed sequences after reset release. Each entry is the value
  // after that enabled edge.
  int   e4_cnt [10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
  logic e4_clk [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  int   e2_cnt [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  logic e2_clk [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  int   e5_cnt [10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
  logic e5_clk [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst     = 1'b1;
    enable  = 1'b1;
    seu4    = 3'b000;
    seu_off = 3'b000;
    repeat (3) step();
    check4("reset4", 0, 1'b0, 1'b0);
    check("reset2.clk", 32'(co2), 32'd0);
    check("reset5.cnt", 32'(cv5), 32'd0);
    check("reset5.err", 32'(te5), 32'd0);

    // Normal counting for all three ratios.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check4($sformatf("run4[%0d]", i), e4_cnt[i], e4_clk[i], 1'b0);
      check($sformatf("run2[%0d].cnt", i), 32'(cv2), 32'(e2_cnt[i]));
      check($sformatf("run2[%0d].clk", i), 32'(co2), 32'(e2_clk[i]));
      check($sformatf("run5[%0d].cnt", i), 32'(cv5), 32'(e5_cnt[i]));
      check($sformatf("run5[%0d].clk", i), 32'(co5), 32'(e5_clk[i]));
    end

    // Freeze at cnt=2, clock_out=1, for 7 edges.
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check4($sformatf("hold[%0d]", i), 2, 1'b1, 1'b0);
    end
    enable = 1'b1;
    step(); check4("resume0", 3, 1'b1, 1'b0);
    step(); check4("resume1", 0, 1'b0, 1'b0);
    step(); check4("resume2", 1, 1'b0, 1'b0);
    step(); check4("resume3", 2, 1'b1, 1'b0);

    // Single upset in replica B. It is outvoted and scrubbed.
    seu4 = 3'b010;
    step();
    check4("seu1.e0", 3, 1'b1, 1'b0);
    check("seu1.cnt_b", 32'(dut4.cnt_b_r), 32'd2);
    seu4 = 3'b000;
    step();
    check4("seu1.e1", 0, 1'b0, 1'b1);
    check("seu1.scrub", 32'(dut4.cnt_b_r), 32'(dut4.cnt_a_r));
    step(); check4("seu1.e2", 1, 1'b0, 1'b0);
    step(); check4("seu1.e3", 2, 1'b1, 1'b0);

    // Synchronous reset mid-period.
    step(); check4("pre_rst", 3, 1'b1, 1'b0);
    rst = 1'b1;
    step(); check4("mid_rst", 0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); check4("post_rst0", 1, 1'b0, 1'b0);
    step(); check4("post_rst1", 2, 1'b1, 1'b0);

    // Double upset in A and B. The count slips by one, then the 4-edge
    // period resumes.
    seu4 = 3'b011;
    step(); check4("seu2.e0", 2, 1'b1, 1'b0);
    seu4 = 3'b000;
    step(); check4("seu2.e1", 3, 1'b1, 1'b1);
    step(); check4("seu2.e2", 0, 1'b0, 1'b0);
    step(); check4("seu2.e3", 1, 1'b0, 1'b0);
    step(); check4("seu2.e4", 2, 1'b1, 1'b0);
    step(); check4("seu2.e5", 3, 1'b1, 1'b0);
    step(); check4("seu2.e6", 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
